// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared widths and FSM state encoding for dotp_mult_seq
package dotp_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [2:0] {
    S_ACCEPT  = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/dotp_acc.sv
// rtl/dotp_acc.sv - dot product accumulator, wrapping or saturating (DOTP_SAT_EN)
module dotp_acc
  import dotp_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [PROD_W-1:0] i_addend,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  logic [ACC_W-1:0] r_acc;

`ifdef DOTP_SAT_EN
  // One extra bit exposes the carry that signals a saturating add.
  logic [ACC_W:0] w_sum;
  logic           r_ovf;

  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(i_addend);

  // Accumulate, clamping at all-ones; overflow flag is sticky until clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      if (w_sum[ACC_W]) begin
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign o_ovf = r_ovf;
`else
  logic [ACC_W-1:0] w_sum;

  assign w_sum = r_acc + ACC_W'(i_addend);

  // Accumulate modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_ovf = 1'b0;
`endif

  assign o_acc = r_acc;

endmodule

// File: rtl/dotp_mult_seq.sv
// rtl/dotp_mult_seq.sv - operand sequencer and dot product accumulator around the add-shift multiplier; option DOTP_SAT_EN
module dotp_mult_seq
  import dotp_pkg::*;
#(
  parameter int N_PAIRS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic              mult_ready,
  input  logic [PROD_W-1:0] mult_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAIRS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_mult_a;
  logic [OP_W-1:0]   r_mult_b;
  logic              w_latch;
  logic              w_add_en;
  logic              w_clr;
  logic              w_cnt_inc;
  logic              w_start;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes; the issue waits for an idle multiplier,
  // then a low-then-high on mult_ready marks a fresh product.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_add_en    = 1'b0;
    w_clr       = 1'b0;
    w_cnt_inc   = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        if (in_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start = mult_ready;
        if (mult_ready) begin
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!mult_ready) begin
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (mult_ready) begin
          w_add_en = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_clr       = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      default: begin
        w_state_nxt = S_ACCEPT;
      end
    endcase
  end

  // Pair counter, cleared when the result is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Operand registers; only loaded on accept so they hold through the multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
    end else if (w_latch) begin
      r_mult_a <= in_a;
      r_mult_b <= in_b;
    end
  end

  dotp_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_add_en (w_add_en),
    .i_addend (mult_result),
    .o_acc    (out_sum),
    .o_ovf    (out_ovf)
  );

  assign in_ready   = (r_state == S_ACCEPT);
  assign busy       = (r_state != S_ACCEPT);
  assign out_valid  = (r_state == S_DONE);
  assign mult_start = w_start;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;

endmodule

// File: tb/tb_dotp_mult_seq.sv
// tb/tb_dotp_mult_seq.sv - directed self-checking bench for dotp_mult_seq (ACC_W=12 and ACC_W=9 in lockstep)
module tb_dotp_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;

  logic [1:0]  in_ready;
  logic [1:0]  mult_start;
  logic [1:0]  mult_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ovf;
  logic [1:0]  busy;
  logic [3:0]  mult_a [2];
  logic [3:0]  mult_b [2];
  logic [7:0]  mult_result [2];
  logic [11:0] sum12;
  logic [8:0]  sum9;

  int n_pass  = 0;
  int n_total = 0;

  dotp_mult_seq #(.N_PAIRS(4), .ACC_W(12)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .mult_start(mult_start[0]),
    .mult_a(mult_a[0]), .mult_b(mult_b[0]), .mult_ready(mult_ready[0]),
    .mult_result(mult_result[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_sum(sum12), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  dotp_mult_seq #(.N_PAIRS(4), .ACC_W(9)) u_dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .mult_start(mult_start[1]),
    .mult_a(mult_a[1]), .mult_b(mult_b[1]), .mult_ready(mult_ready[1]),
    .mult_result(mult_result[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_sum(sum9), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  // Multiplier model: busy 5 cycles after start, samples operands one cycle after start.
  // It is not reset by rst, so a multiply in flight survives a sequencer reset.
  logic [1:0] m_busy = '0;
  logic [1:0] m_samp = '0;
  int         m_cnt [2];
  initial begin
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    mult_result[0] = '0;
    mult_result[1] = '0;
  end
  assign mult_ready = ~m_busy;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k]) begin
        m_samp[k] <= 1'b0;
        if (m_samp[k]) mult_result[k] <= {4'b0, mult_a[k]} * {4'b0, mult_b[k]};
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) m_busy[k] <= 1'b0;
      end else if (mult_start[k]) begin
        m_busy[k] <= 1'b1;
        m_samp[k] <= 1'b1;
        m_cnt[k]  <= 5;
      end
    end
  end

  int   n_starts = 0;
  int   n_dbl    = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    if (mult_start[0]) n_starts <= n_starts + 1;
    if (mult_start[0] && prev_start) n_dbl <= n_dbl + 1;
    prev_start <= mult_start[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Send n pairs from packed nibble vectors; optional idle gap and garbage while busy.
  task automatic run_set(input logic [15:0] av, input logic [15:0] bv, input int n,
                         input int gap, input bit garbage);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!in_ready[0] && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) check("in_ready_timeout", 0, 1);
      if (i > 0) repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_a = av[4*i +: 4];
      in_b = bv[4*i +: 4];
      @(negedge clk);
      if (garbage) begin
        in_a = 4'hF;
        in_b = 4'hA;
        repeat (3) @(negedge clk);
      end
      in_valid = 1'b0;
      in_a = 4'h0;
      in_b = 4'h0;
    end
  endtask

  // Wait for out_valid; lat = negedges between mult_ready rising and out_valid.
  task automatic wait_out(output int lat);
    int   k = 0;
    int   rise_at = -100;
    logic prev_r = mult_ready[0];
    while (!out_valid[0] && k < 300) begin
      @(negedge clk);
      k++;
      if (mult_ready[0] && !prev_r) rise_at = k;
      prev_r = mult_ready[0];
    end
    if (k >= 300) check("out_valid_timeout", 0, 1);
    lat = k - rise_at;
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int lat;
  int s0;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = 4'h0;
    in_b = 4'h0;
    repeat (2) @(negedge clk);

    check("rst_in_ready", in_ready[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_mult_start", mult_start[0], 0);
    check("rst_out_sum", sum12, 0);
    check("rst_out_ovf", out_ovf[0], 0);
    check("rst_mult_ab", {mult_a[0], mult_b[0]}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic sum: 15 + 225 + 0 + 14 = 254
    s0 = n_starts;
    run_set(16'h70F3, 16'h29F5, 4, 0, 1'b0);
    wait_out(lat);
    check("basic_lat", lat, 1);
    check("basic_sum", sum12, 254);
    check("basic_ovf", out_ovf[0], 0);
    check("basic_starts", n_starts - s0, 4);
    check("basic_sum9", sum9, 254);
    take_out();
    check("basic_after_valid", out_valid[0], 0);
    check("basic_after_ready", in_ready[0], 1);
    check("basic_after_sum", sum12, 0);

    // Maximum operands: 4 * 225 = 900; ACC_W=9 either wraps to 388 or clamps to 511
    run_set(16'hFFFF, 16'hFFFF, 4, 0, 1'b0);
    wait_out(lat);
    check("max_sum", sum12, 900);
    check("max_ovf", out_ovf[0], 0);
`ifdef DOTP_SAT_EN
    check("ovf9_sum", sum9, 511);
    check("ovf9_flag", out_ovf[1], 1);
`else
    check("ovf9_sum", sum9, 388);
    check("ovf9_flag", out_ovf[1], 0);
`endif

    // Backpressure: hold S_DONE for 10 cycles
    s0 = n_starts;
    in_valid = 1'b1;
    in_a = 4'h9;
    in_b = 4'h9;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", out_valid[0], 1);
      check("bp_sum", sum12, 900);
      check("bp_in_ready", in_ready[0], 0);
    end
    in_valid = 1'b0;
    check("bp_no_start", n_starts - s0, 0);
    take_out();
    check("bp_ovf9_cleared", out_ovf[1], 0);
    run_set(16'h1111, 16'h1111, 4, 0, 1'b0);
    wait_out(lat);
    check("bp_next_sum", sum12, 4);
    check("bp_next_sum9", sum9, 4);
    take_out();

    // Input stalls with garbage while busy: same as the basic run
    s0 = n_starts;
    run_set(16'h70F3, 16'h29F5, 4, 3, 1'b1);
    wait_out(lat);
    check("stall_sum", sum12, 254);
    check("stall_starts", n_starts - s0, 4);
    take_out();

    // Reset during the 2nd pair's capture wait
    run_set(16'h0054, 16'h0054, 2, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", busy[0], 1);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready[0], 1);
    check("midrst_busy", busy[0], 0);
    check("midrst_sum", sum12, 0);
    check("midrst_mult_a", mult_a[0], 0);
    @(negedge clk);
    rst = 1'b1;
    run_set(16'h2222, 16'h3333, 4, 0, 1'b0);
    wait_out(lat);
    check("midrst_new_sum", sum12, 24);
    take_out();

    check("start_single_cycle", n_dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
